rle_symbol_serializer: RTL and testbench

- Downstream neighbour of the 8-lane combinational run-length stage.
- Accepts one row per handshake: 8 coefficients, 8 nonzero flags and 8 run values. Serializes the row into at most one JPEG-style (run, coefficient) symbol per cycle.
- Run values of 16 or more are split into ZRL symbols. Emits EOB at the end of a block when the block ends in zeros.
- Owns the run-carry register that feeds the run-length stage's incoming zero count. The pair forms a closed loop across the 8 rows of a block.

---
 rtl/rle_symbol_serializer_if.sv | 29 ++
 rtl/rle_symbol_serializer.sv | 126 ++++++++++++
 tb/tb_rle_symbol_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_symbol_serializer_if.sv
// Row and symbol handshakes of the run-length symbol serializer.
// master = row producer / symbol consumer, slave = serializer.
interface rle_symbol_serializer_if #(
    parameter int COEF_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*COEF_W-1:0]   in_coef;
    logic [7:0]            in_en;
    logic [47:0]           in_run;
    logic [5:0]            in_zeros;

    logic                  sym_valid;
    logic                  sym_ready;
    logic [3:0]            sym_run;
    logic [COEF_W-1:0]     sym_coef;
    logic                  sym_zrl;
    logic                  sym_eob;

    modport master (
        output in_valid, in_coef, in_en, in_run, in_zeros, sym_ready,
        input  in_ready, sym_valid, sym_run, sym_coef, sym_zrl, sym_eob
    );

    modport slave (
        input  in_valid, in_coef, in_en, in_run, in_zeros, sym_ready,
        output in_ready, sym_valid, sym_run, sym_coef, sym_zrl, sym_eob
    );
endinterface

// File: rtl/rle_symbol_serializer.sv
// Serializes 8-lane RLE rows into (run, coef) symbols with ZRL splitting,
// end-of-block EOB and the run-carry register feeding the run-length stage.
module rle_symbol_serializer #(
    parameter int COEF_W         = 8,
    parameter int ROWS_PER_BLOCK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    rle_symbol_serializer_if.slave   bus,
    output logic [5:0]               run_carry
);
    localparam int RC_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EOB
    } state_t;

    state_t              state, state_nx;
    logic [COEF_W-1:0]   coef_q [8];
    logic [5:0]          run_q  [8];
    logic [7:0]          mask_q, mask_nx;
    logic [1:0]          zrl_cnt, zrl_nx;
    logic [5:0]          tz_q;
    logic                last_q;
    logic [RC_W-1:0]     row_cnt;

    logic [2:0]          k;
    logic [5:0]          r;
    logic                accept;

    assign accept = bus.in_valid && bus.in_ready;

    // Lane 0 has priority: scanning from lane 7 down leaves the lowest set lane.
    always_comb begin
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) k = 3'(i);
        end
    end

    assign r = run_q[k] - {zrl_cnt, 4'b0000};

    always_comb begin
        state_nx      = state;
        mask_nx       = mask_q;
        zrl_nx        = zrl_cnt;
        bus.in_ready  = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_run   = 4'd0;
        bus.sym_coef  = '0;
        bus.sym_zrl   = 1'b0;
        bus.sym_eob   = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) state_nx = SCAN;
            end
            SCAN: begin
                if (mask_q == 8'd0) begin
                    state_nx = (last_q && tz_q != 6'd0) ? EOB : IDLE;
                end else if (r >= 6'd16) begin
                    bus.sym_valid = 1'b1;
                    bus.sym_run   = 4'hf;
                    bus.sym_zrl   = 1'b1;
                    if (bus.sym_ready) zrl_nx = zrl_cnt + 2'd1;
                end else begin
                    bus.sym_valid = 1'b1;
                    bus.sym_run   = r[3:0];
                    bus.sym_coef  = coef_q[k];
                    if (bus.sym_ready) begin
                        mask_nx[k] = 1'b0;
                        zrl_nx     = 2'd0;
                    end
                end
            end
            EOB: begin
                bus.sym_valid = 1'b1;
                bus.sym_eob   = 1'b1;
                if (bus.sym_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mask_q    <= 8'd0;
            zrl_cnt   <= 2'd0;
            tz_q      <= 6'd0;
            last_q    <= 1'b0;
            row_cnt   <= '0;
            run_carry <= 6'd0;
        end else begin
            state   <= state_nx;
            mask_q  <= mask_nx;
            zrl_cnt <= zrl_nx;
            if (accept) begin
                for (int i = 0; i < 8; i++) mask_q[i] <= bus.in_en[7-i];
                zrl_cnt <= 2'd0;
                tz_q    <= bus.in_zeros;
                last_q  <= (row_cnt == LAST_ROW);
                // The carry restarts at each block boundary.
                if (row_cnt == LAST_ROW) begin
                    row_cnt   <= '0;
                    run_carry <= 6'd0;
                end else begin
                    row_cnt   <= row_cnt + 1'b1;
                    run_carry <= bus.in_zeros;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= bus.in_coef[(7-i)*COEF_W +: COEF_W];
                run_q[i]  <= bus.in_run[(7-i)*6 +: 6];
            end
        end
    end
endmodule

// File: tb/tb_rle_symbol_serializer.sv
// Directed bench for rle_symbol_serializer: symbol order, ZRL/EOB,
// run_carry, throughput, backpressure hold and mid-row reset.
module tb_rle_symbol_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] run_carry;

    always #5 clk = ~clk;

    rle_symbol_serializer_if #(.COEF_W(8)) bus ();

    rle_symbol_serializer #(
        .COEF_W(8),
        .ROWS_PER_BLOCK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .run_carry(run_carry)
    );

    int n_chk = 0;
    int n_err = 0;
    int dead_cnt = 0;
    int lat;

    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];

    localparam logic [13:0] S_ZRL = {2'b01, 4'hf, 8'h00};
    localparam logic [13:0] S_EOB = {2'b10, 4'h0, 8'h00};

    logic       bp_mode = 1'b0;
    int         bp_idx  = 0;
    logic [5:0] pat     = 6'b100101;

    logic        prev_stall = 1'b0;
    logic [13:0] prev_word  = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [13:0] sp(input logic [3:0] rn,
                                       input logic [7:0] cf);
        sp = {2'b00, rn, cf};
    endfunction

    function automatic logic [63:0] cl(input int lane, input logic [7:0] v);
        cl = '0;
        cl[63-8*lane -: 8] = v;
    endfunction

    function automatic logic [47:0] rl(input int lane, input logic [5:0] v);
        rl = '0;
        rl[47-6*lane -: 6] = v;
    endfunction

    function automatic logic [7:0] el(input int lane);
        el = 8'h80 >> lane;
    endfunction

    function automatic logic [13:0] cur_word();
        cur_word = {bus.sym_eob, bus.sym_zrl, bus.sym_run, bus.sym_coef};
    endfunction

    // Ready driver: always high unless the backpressure pattern is active.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bus.sym_ready = pat[5-bp_idx];
            bp_idx = (bp_idx + 1) % 6;
        end else begin
            bus.sym_ready = 1'b1;
            bp_idx = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {17'd0, bus.sym_valid, cur_word()},
                    {17'd0, 1'b1, prev_word});
            if (bus.sym_valid && bus.sym_ready) got_q.push_back(cur_word());
            if (!bus.sym_valid && !bus.in_ready) dead_cnt++;
            prev_stall = bus.sym_valid && !bus.sym_ready;
            prev_word  = cur_word();
        end
    end

    task automatic send_row(input logic [63:0] c, input logic [7:0] e,
                            input logic [47:0] rn, input logic [5:0] z);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        bus.in_en    = e;
        bus.in_run   = rn;
        bus.in_zeros = z;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(n < 200), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_syms(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, {18'd0, got_q[i]}, {18'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_coef  = '0;
        bus.in_en    = '0;
        bus.in_run   = '0;
        bus.in_zeros = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_valid", bus.sym_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_run_carry", run_carry, 0);
        chk("rst_sym_fields", {18'd0, cur_word()}, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Block 1: two symbols in row 0, zero rows after, EOB at the end.
        dead_cnt = 0;
        send_row(cl(0, 8'h05) | cl(3, 8'h03), el(0) | el(3),
                 rl(0, 6'd0) | rl(3, 6'd2), 6'd4);
        chk("carry_row0", run_carry, 4);
        wait_idle(lat);
        chk("lat_row0", lat, 3);
        for (int rw = 1; rw < 8; rw++) begin
            send_row('0, 8'h00, '0, 6'(4 + 8 * rw));
            chk("carry_row", run_carry, (rw == 7) ? 0 : 4 + 8 * rw);
            wait_idle(lat);
            chk("lat_row", lat, (rw == 7) ? 2 : 1);
            if (rw == 6) chk("no_early_eob", got_q.size(), 2);
        end
        exp_q.push_back(sp(4'd0, 8'h05));
        exp_q.push_back(sp(4'd2, 8'h03));
        exp_q.push_back(S_EOB);
        cmp_syms("blk1");
        chk("blk1_dead", dead_cnt, 8);

        // Run 20 splits into one ZRL and (4, 0x7F).
        send_row(cl(5, 8'h7f), el(5), rl(5, 6'd20), 6'd2);
        chk("carry_zrl1", run_carry, 2);
        wait_idle(lat);
        chk("lat_zrl1", lat, 3);
        exp_q.push_back(S_ZRL);
        exp_q.push_back(sp(4'd4, 8'h7f));
        cmp_syms("zrl1");

        // Fill rows up to the last one, then run 63 on lane 7 with no EOB.
        for (int rw = 2; rw < 8; rw++) begin
            send_row('0, 8'h00, '0, 6'd1);
            wait_idle(lat);
        end
        chk("pre_last_syms", got_q.size(), 0);
        send_row(cl(7, 8'h01), el(7), rl(7, 6'd63), 6'd0);
        chk("carry_last", run_carry, 0);
        chk("row_cnt_wrap", dut.row_cnt, 0);
        wait_idle(lat);
        chk("lat_zrl3", lat, 5);
        exp_q.push_back(S_ZRL);
        exp_q.push_back(S_ZRL);
        exp_q.push_back(S_ZRL);
        exp_q.push_back(sp(4'd15, 8'h01));
        cmp_syms("zrl3");

        // Backpressure: ready pattern 1,0,0,1,0,1 repeating.
        bp_mode = 1'b1;
        send_row(cl(1, 8'h11) | cl(4, 8'h22) | cl(6, 8'h33),
                 el(1) | el(4) | el(6),
                 rl(1, 6'd1) | rl(4, 6'd3) | rl(6, 6'd5), 6'd0);
        wait_idle(lat);
        bp_mode = 1'b0;
        exp_q.push_back(sp(4'd1, 8'h11));
        exp_q.push_back(sp(4'd3, 8'h22));
        exp_q.push_back(sp(4'd5, 8'h33));
        cmp_syms("bp");

        // Reset while the second ZRL of a run-40 symbol is presented.
        send_row(cl(0, 8'h09), el(0), rl(0, 6'd40), 6'd7);
        chk("carry_pre_rst", run_carry, 7);
        chk("row_cnt_pre_rst", dut.row_cnt, 2);
        @(posedge clk);
        #1;
        chk("zrl2_present", {bus.sym_valid, bus.sym_zrl}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_sym_valid", bus.sym_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_run_carry", run_carry, 0);
        chk("mrst_row_cnt", dut.row_cnt, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mrst_still_idle", bus.in_ready, 1);
        exp_q.push_back(S_ZRL);
        cmp_syms("mrst");

        // All-zero block: only one EOB after row 7.
        dead_cnt = 0;
        for (int rw = 0; rw < 8; rw++) begin
            send_row('0, 8'h00, '0, 6'd8);
            wait_idle(lat);
            if (rw == 6) chk("zero_blk_early", got_q.size(), 0);
        end
        exp_q.push_back(S_EOB);
        cmp_syms("zero_blk");
        chk("zero_blk_dead", dead_cnt, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
